// File: rtl/fifo_queue_if.sv
// Producer/consumer bundle for fifo_queue.
// QUEUE_ERROR_FLAGS_EN adds sticky overflow/underflow status.
interface fifo_queue_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  enqueue;
  logic                  dequeue;
  logic                  peek;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  is_empty;
  logic                  is_full;
`ifdef QUEUE_ERROR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
`endif

  modport master (
    output enqueue,
    output dequeue,
    output peek,
    output data_in,
    input  data_out,
    input  is_empty,
`ifdef QUEUE_ERROR_FLAGS_EN
    input  overflow,
    input  underflow,
`endif
    input  is_full
  );

  modport slave (
    input  enqueue,
    input  dequeue,
    input  peek,
    input  data_in,
    output data_out,
    output is_empty,
`ifdef QUEUE_ERROR_FLAGS_EN
    output overflow,
    output underflow,
`endif
    output is_full
  );
endinterface

// File: rtl/fifo_queue.sv
// Circular-buffer byte FIFO with registered read data and peek.
// QUEUE_ERROR_FLAGS_EN adds sticky overflow/underflow outputs.
module fifo_queue #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  localparam int PTR_WIDTH  = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        rst,
  fifo_queue_if.slave q
);
  localparam int TOP_W = PTR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  rptr;
  logic [PTR_WIDTH-1:0]  wptr;
  logic [TOP_W-1:0]      top;
  logic [TOP_W-1:0]      top_next;

  logic empty;
  logic full;
  logic deq_ok;
  logic enq_ok;
  logic peek_ok;

  assign empty   = (top == '0);
  assign full    = (top == TOP_W'(DEPTH));
  assign deq_ok  = q.dequeue && !empty;
  // A pop in the same cycle frees the slot a full queue needs
  assign enq_ok  = q.enqueue && (!full || deq_ok);
  assign peek_ok = q.peek && !q.dequeue && !empty;

  always_comb begin
    top_next = top;
    unique case (1'b1)
      enq_ok && !deq_ok: top_next = top + TOP_W'(1);
      deq_ok && !enq_ok: top_next = top - TOP_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq_ok)
      mem[wptr] <= q.data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr       <= '0;
      wptr       <= '0;
      top        <= '0;
      q.data_out <= '0;
      q.is_empty <= 1'b1;
      q.is_full  <= 1'b0;
    end else begin
      if (enq_ok)
        wptr <= wptr + PTR_WIDTH'(1);
      if (deq_ok)
        rptr <= rptr + PTR_WIDTH'(1);
      if (deq_ok || peek_ok)
        q.data_out <= mem[rptr];
      top        <= top_next;
      q.is_empty <= (top_next == '0);
      q.is_full  <= (top_next == TOP_W'(DEPTH));
    end
  end

`ifdef QUEUE_ERROR_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q.overflow  <= 1'b0;
      q.underflow <= 1'b0;
    end else begin
      if (q.enqueue && !enq_ok)
        q.overflow <= 1'b1;
      if ((q.dequeue || q.peek) && empty)
        q.underflow <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_queue.sv
// Scoreboard bench for fifo_queue: directed ops queue expectations,
// a negedge monitor pops and compares them.
module tb_fifo_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic exp_ov = 1'b0;
  logic exp_un = 1'b0;

  typedef struct {
    int         tag;
    logic [7:0] d;
    logic [3:0] t;
    logic       e;
    logic       f;
    logic       ov;
    logic       un;
  } exp_t;

  exp_t sb[$];
  exp_t mx;

  fifo_queue_if #(.DATA_WIDTH(8)) q ();

  fifo_queue #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .q  (q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      mx = sb.pop_front();
      chk("tag", mx.tag, cyc);
      chk("data_out", q.data_out, mx.d);
      chk("top", dut.top, mx.t);
      chk("is_empty", q.is_empty, mx.e);
      chk("is_full", q.is_full, mx.f);
`ifdef QUEUE_ERROR_FLAGS_EN
      chk("overflow", q.overflow, mx.ov);
      chk("underflow", q.underflow, mx.un);
`endif
    end
  end

  task automatic op(input logic en, input logic dq, input logic pk,
                    input logic [7:0] din, input logic [7:0] ed,
                    input int et);
    exp_t x;
    x.tag = cyc + 1;
    x.d   = ed;
    x.t   = et[3:0];
    x.e   = (et == 0);
    x.f   = (et == 8);
    x.ov  = exp_ov;
    x.un  = exp_un;
    sb.push_back(x);
    q.enqueue = en;
    q.dequeue = dq;
    q.peek    = pk;
    q.data_in = din;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_data_out"}, q.data_out, 0);
    chk({nm, "_is_empty"}, q.is_empty, 1);
    chk({nm, "_is_full"}, q.is_full, 0);
    chk({nm, "_top"}, dut.top, 0);
`ifdef QUEUE_ERROR_FLAGS_EN
    chk({nm, "_overflow"}, q.overflow, 0);
    chk({nm, "_underflow"}, q.underflow, 0);
`endif
  endtask

  initial begin
    q.enqueue = 1'b0;
    q.dequeue = 1'b0;
    q.peek    = 1'b0;
    q.data_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk_reset("rst_init");
    rst = 1'b0;

    op(1, 0, 0, 8'hA1, 8'h00, 1);
    op(1, 0, 0, 8'hA2, 8'h00, 2);
    op(1, 0, 0, 8'hA3, 8'h00, 3);
    #2 rst = 1'b1;
    #1 chk_reset("rst_async");
    @(negedge clk);
    rst = 1'b0;

    op(1, 0, 0, 8'h11, 8'h00, 1);
    op(1, 0, 0, 8'h22, 8'h00, 2);
    op(1, 0, 0, 8'h33, 8'h00, 3);
    op(1, 0, 0, 8'h44, 8'h00, 4);
    op(0, 0, 1, 8'h00, 8'h11, 4);
    op(0, 1, 0, 8'h00, 8'h11, 3);
    op(0, 1, 0, 8'h00, 8'h22, 2);
    op(0, 1, 0, 8'h00, 8'h33, 1);
    op(0, 1, 0, 8'h00, 8'h44, 0);

    exp_un = 1'b1;
    op(0, 1, 0, 8'h00, 8'h44, 0);

    for (int i = 0; i < 8; i++)
      op(1, 0, 0, 8'h55 + 8'(i * 17), 8'h44, i + 1);
    exp_ov = 1'b1;
    op(1, 0, 0, 8'hDD, 8'h44, 8);
    for (int i = 0; i < 8; i++)
      op(0, 1, 0, 8'h00, 8'h55 + 8'(i * 17), 7 - i);

    for (int i = 0; i < 8; i++)
      op(1, 0, 0, 8'(i + 1), 8'hCC, i + 1);
    op(1, 1, 0, 8'hEE, 8'h01, 8);
    for (int i = 0; i < 7; i++)
      op(0, 1, 0, 8'h00, 8'(i + 2), 7 - i);
    op(0, 1, 0, 8'h00, 8'hEE, 0);

    op(1, 1, 0, 8'h5A, 8'hEE, 1);
    op(0, 1, 0, 8'h00, 8'h5A, 0);
    op(1, 0, 0, 8'h6B, 8'h5A, 1);
    op(1, 0, 0, 8'h7C, 8'h5A, 2);
    op(0, 1, 1, 8'h00, 8'h6B, 1);
    op(0, 0, 1, 8'h00, 8'h7C, 1);
    op(0, 1, 0, 8'h00, 8'h7C, 0);
    op(0, 0, 1, 8'h00, 8'h7C, 0);
    op(0, 0, 0, 8'h00, 8'h7C, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
